control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clock port named Clock and reset port named Clear.
REQ-002 Ports, one per line:
  Clock  in  1  rising-edge system clock
  Clear  in  1  asynchronous active-low reset
  IR  in  32  instruction register; opcode IR[31:27]
  Mem_ready  in  1  memory-complete strobe, valid in memory-wait states
  Stop  in  1  halt request, sampled in T0
  PCout, ZHighout, Zlowout, MDRout  out  1 each  bus drive enables
  PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHighIn, ZLowIn  out  1 each  register loads
  Gra, Grb, Grc, Rin, Rout, Cout  out  1 each  select-and-encode controls
  IncPC, Read, Write  out  1 each  PC increment; memory read; memory write
  ALU_op  out  5  ALU operation select
  Run  out  1  high while executing, low in RST and HALT

Function
REQ-003 SHALL be a Moore FSM; every output is a function of the state register alone, and unlisted outputs are 0.
REQ-004 States: RST, T0..T7, HALT; transitions on rising Clock only.
REQ-005 RST: all outputs 0; next state T0.
REQ-006 T0: PCout, MARin, IncPC, ZLowIn; ALU_op=ALU_ADD; next T1, or HALT if Stop=1.
REQ-007 T1: Zlowout, PCin, Read, MDRin; stay in T1 while Mem_ready=0; go to T2 when Mem_ready=1. PCin SHALL be asserted only in the first T1 cycle.
REQ-008 T2: MDRout, IRin; next T3. NOP and undefined opcodes return to T0; HALT opcode goes to HALT.
REQ-009 R-type (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLowIn, ALU_op=opcode.
  - T5: Zlowout, Gra, Rin; next T0.
REQ-010 ADDI/ANDI/ORI: same as REQ-009, except T4 asserts Cout instead of Grc, Rout, with ALU_op=ALU_ADD/ALU_AND/ALU_OR.
REQ-011 LD:
  - T3 as REQ-009.
  - T4: Cout, ZLowIn, ALU_op=ALU_ADD.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold until Mem_ready=1.
  - T7: MDRout, Gra, Rin; next T0.
REQ-012 ST:
  - T3..T5 as LD.
  - T6: Gra, Rout, MDRin, with Read=0.
  - T7: Write; hold until Mem_ready=1; next T0.
REQ-013 MUL/DIV:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ZHighIn, ZLowIn, ALU_op=opcode.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin; next T0.
REQ-014 HALT: all outputs 0, Run=0; leaves HALT only through Clear.
REQ-015 IR SHALL be sampled for decode only in T2 and T3..T7; IR changes outside those states SHALL have no effect.
REQ-016 Mem_ready asserted outside T1/T6(LD)/T7(ST) SHALL be ignored.
REQ-017 Stop asserted outside T0 SHALL take effect at the next T0.

Reset
REQ-018 Clear low SHALL force RST immediately, regardless of Clock, including mid-instruction or while waiting on Mem_ready.
REQ-019 While Clear is low, all outputs SHALL be 0 and Run=0.
REQ-020 The first rising Clock after Clear rises SHALL enter T0.

Structure
REQ-021 A shared package SHALL hold:
  - opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, SHR 00100, SHL 00101, ROR 00110, ROL 00111, ADDI 01000, ANDI 01001, ORI 01010, LD 01011, ST 01100, MUL 01101, DIV 01110, NOP 01111, HALT 10000;
  - ALU_op codes, where ALU_op equals the opcode for R-type and MUL/DIV;
  - the state encoding.
REQ-022 A single sub-module, opcode_decoder (IR[31:27] to instruction class), SHALL be instantiated; everything else stays flat.

Verification
REQ-023 IR=0x02920000 (add R5,R2,R4), Mem_ready=1 in T1 -> 6-cycle T0..T5 sequence; ALU_op=00000 in T4; Gra+Rin+Zlowout in T5; back to T0.
REQ-024 IR=0x58900010 (ld R1,0x10(R2)), Mem_ready held 0 for 3 cycles in T6 -> stays in T6 with Read+MDRin for 4 cycles; T7 asserts MDRout+Gra+Rin.
REQ-025 IR=0x68000000 (mul) -> T4 asserts ZHighIn+ZLowIn with ALU_op=01101; LOin in T5; HIin in T6.
REQ-026 IR=0x80000000 (halt) -> after T2 enters HALT, Run=0; outputs stay 0 for 20 cycles; Clear pulse gives RST then T0.
REQ-027 Clear driven low mid-T4 of an add, between clock edges -> all outputs 0 immediately; after release, first edge enters T0.
REQ-028 Stop=1 during T0 -> HALT on the next edge, with no Read or PCin ever asserted.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU operation codes,
// state encoding and instruction classes.
package control_unit_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_ROR  = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_LD   = 5'b01011;
  localparam logic [4:0] OP_ST   = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01101;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b10000;

  // ALU codes coincide with the opcodes of the R-type and MUL/DIV instructions
  localparam logic [4:0] ALU_ADD = OP_ADD;
  localparam logic [4:0] ALU_SUB = OP_SUB;
  localparam logic [4:0] ALU_AND = OP_AND;
  localparam logic [4:0] ALU_OR  = OP_OR;
  localparam logic [4:0] ALU_SHR = OP_SHR;
  localparam logic [4:0] ALU_SHL = OP_SHL;
  localparam logic [4:0] ALU_ROR = OP_ROR;
  localparam logic [4:0] ALU_ROL = OP_ROL;
  localparam logic [4:0] ALU_MUL = OP_MUL;
  localparam logic [4:0] ALU_DIV = OP_DIV;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST, CLS_MULDIV, CLS_NOP, CLS_HALT
  } instr_class_t;

  function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
    case (opcode)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_opcode_decoder.sv
// Maps a 5-bit opcode onto the instruction class that steers the FSM.
// Undefined opcodes are treated as NOP.
module opcode_decoder
  import control_unit_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       cls = CLS_IMM;
      OP_LD:                          cls = CLS_LD;
      OP_ST:                          cls = CLS_ST;
      OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
      OP_HALT:                        cls = CLS_HALT;
      default:                        cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore-style instruction sequencer generating datapath control strobes.
//
//   state | meaning
//   RST   | post-reset, all outputs idle
//   T0    | PC to MAR, PC+1 into Z; halt if a stop is requested
//   T1    | instruction fetch, PC update on first cycle, waits on Mem_ready
//   T2    | MDR to IR, opcode captured and decoded
//   T3-T7 | execute steps, contents depend on instruction class
//   HALT  | stopped, left only through Clear
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        ZHighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Cout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_op,
  output logic        Run
);

  state_t       state_q, state_d;
  logic [4:0]   op_q;
  logic         in_t1_q;
  logic         stop_pending_q;
  logic [4:0]   dec_opcode;
  instr_class_t cls;
  logic         unused_ir;

  assign unused_ir = ^IR[26:0];

  // T2 decodes the live opcode; later steps use the copy captured in T2
  assign dec_opcode = (state_q == ST_T2) ? IR[31:27] : op_q;

  opcode_decoder u_opcode_decoder (
    .opcode (dec_opcode),
    .cls    (cls)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q        <= ST_RST;
      op_q           <= OP_NOP;
      in_t1_q        <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_t1_q <= (state_q == ST_T1);
      if (state_q == ST_T2) op_q <= IR[31:27];
      // a stop request seen mid-instruction is held until the next T0
      if (state_q == ST_T0)  stop_pending_q <= 1'b0;
      else if (Stop)         stop_pending_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    ZHighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ZHighIn  = 1'b0;
    ZLowIn   = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    Cout     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    ALU_op   = ALU_ADD;
    Run      = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
        ALU_op  = ALU_ADD;
        state_d = (Stop || stop_pending_q) ? ST_HALT : ST_T1;
      end
      ST_T1: begin
        Run = 1'b1; Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin = !in_t1_q;
        if (Mem_ready) state_d = ST_T2;
      end
      ST_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        case (cls)
          CLS_NOP:  state_d = ST_T0;
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_T3;
        endcase
      end
      ST_T3: begin
        Run = 1'b1; Rout = 1'b1; Yin = 1'b1;
        if (cls == CLS_MULDIV) Gra = 1'b1;
        else                   Grb = 1'b1;
        state_d = ST_T4;
      end
      ST_T4: begin
        Run = 1'b1; ZLowIn = 1'b1;
        case (cls)
          CLS_RTYPE:  begin Grc = 1'b1; Rout = 1'b1; ALU_op = op_q; end
          CLS_IMM:    begin Cout = 1'b1; ALU_op = imm_alu_op(op_q); end
          CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ALU_op = op_q; end
          default:    begin Cout = 1'b1; ALU_op = ALU_ADD; end
        endcase
        state_d = ST_T5;
      end
      ST_T5: begin
        Run = 1'b1; Zlowout = 1'b1;
        case (cls)
          CLS_LD, CLS_ST: begin MARin = 1'b1; state_d = ST_T6; end
          CLS_MULDIV:     begin LOin = 1'b1; state_d = ST_T6; end
          default:        begin Gra = 1'b1; Rin = 1'b1; state_d = ST_T0; end
        endcase
      end
      ST_T6: begin
        Run = 1'b1;
        case (cls)
          CLS_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            if (Mem_ready) state_d = ST_T7;
          end
          CLS_ST:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = ST_T7; end
          default: begin ZHighout = 1'b1; HIin = 1'b1; state_d = ST_T0; end
        endcase
      end
      ST_T7: begin
        Run = 1'b1;
        if (cls == CLS_ST) begin
          Write = 1'b1;
          if (Mem_ready) state_d = ST_T0;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_d = ST_T0;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: a per-instruction expected-output trace
// is built from the instruction rules and compared cycle by cycle.
module tb_control_unit;

  logic        Clock, Clear, Mem_ready, Stop;
  logic [31:0] IR;
  logic PCout, ZHighout, Zlowout, MDRout, PCin, IRin, MARin, MDRin, Yin, HIin, LOin;
  logic ZHighIn, ZLowIn, Gra, Grb, Grc, Rin, Rout, Cout, IncPC, Read, Write, Run;
  logic [4:0] ALU_op;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Cout(Cout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ALU_op(ALU_op), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [22:0] B_PCOUT    = 23'd1 << 22;
  localparam logic [22:0] B_ZHIGHOUT = 23'd1 << 21;
  localparam logic [22:0] B_ZLOWOUT  = 23'd1 << 20;
  localparam logic [22:0] B_MDROUT   = 23'd1 << 19;
  localparam logic [22:0] B_PCIN     = 23'd1 << 18;
  localparam logic [22:0] B_IRIN     = 23'd1 << 17;
  localparam logic [22:0] B_MARIN    = 23'd1 << 16;
  localparam logic [22:0] B_MDRIN    = 23'd1 << 15;
  localparam logic [22:0] B_YIN      = 23'd1 << 14;
  localparam logic [22:0] B_HIIN     = 23'd1 << 13;
  localparam logic [22:0] B_LOIN     = 23'd1 << 12;
  localparam logic [22:0] B_ZHIGHIN  = 23'd1 << 11;
  localparam logic [22:0] B_ZLOWIN   = 23'd1 << 10;
  localparam logic [22:0] B_GRA      = 23'd1 << 9;
  localparam logic [22:0] B_GRB      = 23'd1 << 8;
  localparam logic [22:0] B_GRC      = 23'd1 << 7;
  localparam logic [22:0] B_RIN      = 23'd1 << 6;
  localparam logic [22:0] B_ROUT     = 23'd1 << 5;
  localparam logic [22:0] B_COUT     = 23'd1 << 4;
  localparam logic [22:0] B_INCPC    = 23'd1 << 3;
  localparam logic [22:0] B_READ     = 23'd1 << 2;
  localparam logic [22:0] B_WRITE    = 23'd1 << 1;
  localparam logic [22:0] B_RUN      = 23'd1;
  localparam logic [22:0] T0_CTL = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_RUN;

  logic [22:0] ctl_vec;
  assign ctl_vec = {PCout, ZHighout, Zlowout, MDRout, PCin, IRin, MARin, MDRin, Yin,
                    HIin, LOin, ZHighIn, ZLowIn, Gra, Grb, Grc, Rin, Rout, Cout,
                    IncPC, Read, Write, Run};

  typedef struct {
    logic [22:0] ctl;
    logic [4:0]  alu;
    logic        mr;
    logic        hold;
    logic        stop;
  } ent_t;

  ent_t        tr[$];
  logic [27:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [22:0] c, input logic [4:0] a,
                               input logic m, input logic h, input logic s);
    ent_t e;
    e.ctl = c; e.alu = a; e.mr = m; e.hold = h; e.stop = s;
    tr.push_back(e);
  endfunction

  // Expected per-cycle outputs of one instruction, starting in T0
  function automatic void build(input logic [4:0] op, input int w1, input int w6, input int w7);
    int o;
    o = op;
    push(T0_CTL, 5'd0, rbit(), 1'b0, 1'b0);
    for (int i = 0; i <= w1; i++)
      push(B_ZLOWOUT | B_READ | B_MDRIN | B_RUN | ((i == 0) ? B_PCIN : 23'd0), 5'd0,
           (i == w1), 1'b0, 1'b0);
    push(B_MDROUT | B_IRIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
    if (o <= 10) begin
      push(B_GRB | B_ROUT | B_YIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      if (o <= 7) push(B_GRC | B_ROUT | B_ZLOWIN | B_RUN, op, rbit(), 1'b1, 1'b0);
      else push(B_COUT | B_ZLOWIN | B_RUN, (o == 8) ? 5'd0 : (o == 9) ? 5'd2 : 5'd3,
                rbit(), 1'b1, 1'b0);
      push(B_ZLOWOUT | B_GRA | B_RIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
    end else if (o == 11 || o == 12) begin
      push(B_GRB | B_ROUT | B_YIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      push(B_COUT | B_ZLOWIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      push(B_ZLOWOUT | B_MARIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      if (o == 11) begin
        for (int i = 0; i <= w6; i++)
          push(B_READ | B_MDRIN | B_RUN, 5'd0, (i == w6), 1'b1, 1'b0);
        push(B_MDROUT | B_GRA | B_RIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      end else begin
        push(B_GRA | B_ROUT | B_MDRIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
        for (int i = 0; i <= w7; i++)
          push(B_WRITE | B_RUN, 5'd0, (i == w7), 1'b1, 1'b0);
      end
    end else if (o == 13 || o == 14) begin
      push(B_GRA | B_ROUT | B_YIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      push(B_GRB | B_ROUT | B_ZHIGHIN | B_ZLOWIN | B_RUN, op, rbit(), 1'b1, 1'b0);
      push(B_ZLOWOUT | B_LOIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
      push(B_ZHIGHOUT | B_HIIN | B_RUN, 5'd0, rbit(), 1'b1, 1'b0);
    end
  endfunction

  task automatic cyc(input logic [31:0] ir, input logic mr, input logic stop,
                     output logic [27:0] obs);
    IR = ir; Mem_ready = mr; Stop = stop;
    @(negedge Clock);
    obs = {ctl_vec, ALU_op};
    @(posedge Clock);
    #1;
  endtask

  task automatic run_trace(input logic [31:0] ir, input int n);
    logic [27:0] o;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      cyc(tr[i].hold ? ir : $urandom(), tr[i].mr, tr[i].stop, o);
      obs_q.push_back(o);
    end
  endtask

  task automatic do_reset();
    Clear = 1'b0; Stop = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock); Clear = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Clear = 1'b0; IR = $urandom(); Mem_ready = 1'b1; Stop = 1'b0;
    #12;
    n_checks++;
    if ({ctl_vec, ALU_op} !== 28'd0) begin
      n_fail++; $display("FAIL reset_low: got %h, expected %h", {ctl_vec, ALU_op}, 28'd0);
    end
    @(negedge Clock); Clear = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if ({ctl_vec, ALU_op} !== {T0_CTL, 5'd0}) begin
      n_fail++; $display("FAIL reset_first_edge: got %h, expected %h", {ctl_vec, ALU_op}, {T0_CTL, 5'd0});
    end
  endtask

  task automatic test_add();
    tr.delete(); build(5'b00000, 0, 0, 0);
    run_trace(32'h02920000, tr.size());
    n_checks++;
    if (tr.size() != 6) begin
      n_fail++; $display("FAIL add_len: got %0d, expected 6", tr.size());
    end
    for (int i = 0; i < tr.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
        n_fail++; $display("FAIL add step %0d: got %h, expected %h", i, obs_q[i], {tr[i].ctl, tr[i].alu});
      end
    end
    n_checks++;
    if ({ctl_vec, ALU_op} !== {T0_CTL, 5'd0}) begin
      n_fail++; $display("FAIL add_return_t0: got %h, expected %h", {ctl_vec, ALU_op}, {T0_CTL, 5'd0});
    end
  endtask

  task automatic test_ld_wait();
    tr.delete(); build(5'b01011, $urandom_range(0, 2), 3, 0);
    run_trace(32'h58900010, tr.size());
    for (int i = 0; i < tr.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
        n_fail++; $display("FAIL ld_wait step %0d: got %h, expected %h", i, obs_q[i], {tr[i].ctl, tr[i].alu});
      end
    end
  endtask

  task automatic test_mul();
    tr.delete(); build(5'b01101, 1, 0, 0);
    run_trace(32'h68000000, tr.size());
    for (int i = 0; i < tr.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
        n_fail++; $display("FAIL mul step %0d: got %h, expected %h", i, obs_q[i], {tr[i].ctl, tr[i].alu});
      end
    end
  endtask

  task automatic test_halt();
    tr.delete(); build(5'b10000, $urandom_range(0, 2), 0, 0);
    for (int i = 0; i < 20; i++) push(23'd0, 5'd0, rbit(), 1'b0, rbit());
    run_trace(32'h80000000, tr.size());
    for (int i = 0; i < tr.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
        n_fail++; $display("FAIL halt step %0d: got %h, expected %h", i, obs_q[i], {tr[i].ctl, tr[i].alu});
      end
    end
    #2 Clear = 1'b0;
    #1;
    n_checks++;
    if ({ctl_vec, ALU_op} !== 28'd0) begin
      n_fail++; $display("FAIL halt_clear: got %h, expected %h", {ctl_vec, ALU_op}, 28'd0);
    end
    @(negedge Clock); Clear = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if ({ctl_vec, ALU_op} !== {T0_CTL, 5'd0}) begin
      n_fail++; $display("FAIL halt_restart: got %h, expected %h", {ctl_vec, ALU_op}, {T0_CTL, 5'd0});
    end
  endtask

  task automatic test_clear_mid();
    tr.delete(); build(5'b00000, 0, 0, 0);
    run_trace(32'h02920000, 4);
    n_checks++;
    if ({ctl_vec, ALU_op} !== {tr[4].ctl, tr[4].alu}) begin
      n_fail++; $display("FAIL clear_mid_in_t4: got %h, expected %h", {ctl_vec, ALU_op}, {tr[4].ctl, tr[4].alu});
    end
    #2 Clear = 1'b0;
    #1;
    n_checks++;
    if ({ctl_vec, ALU_op} !== 28'd0) begin
      n_fail++; $display("FAIL clear_async: got %h, expected %h", {ctl_vec, ALU_op}, 28'd0);
    end
    @(posedge Clock); #1;
    n_checks++;
    if ({ctl_vec, ALU_op} !== 28'd0) begin
      n_fail++; $display("FAIL clear_held: got %h, expected %h", {ctl_vec, ALU_op}, 28'd0);
    end
    @(negedge Clock); Clear = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if ({ctl_vec, ALU_op} !== {T0_CTL, 5'd0}) begin
      n_fail++; $display("FAIL clear_release: got %h, expected %h", {ctl_vec, ALU_op}, {T0_CTL, 5'd0});
    end
  endtask

  task automatic test_stop();
    tr.delete();
    push(T0_CTL, 5'd0, rbit(), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) push(23'd0, 5'd0, rbit(), 1'b0, rbit());
    run_trace($urandom(), tr.size());
    for (int i = 0; i < tr.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
        n_fail++; $display("FAIL stop step %0d: got %h, expected %h", i, obs_q[i], {tr[i].ctl, tr[i].alu});
      end
    end
    do_reset();
  endtask

  task automatic test_stop_pulse();
    tr.delete(); build(5'b00001, 1, 0, 0);
    tr[4].stop = 1'b1;
    push(T0_CTL, 5'd0, rbit(), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(23'd0, 5'd0, rbit(), 1'b0, 1'b0);
    run_trace(32'h0A920000, tr.size());
    for (int i = 0; i < tr.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
        n_fail++; $display("FAIL stop_pulse step %0d: got %h, expected %h", i, obs_q[i], {tr[i].ctl, tr[i].alu});
      end
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op;
    logic [31:0] ir;
    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b10000) op = 5'b01111;
      ir = {op, 27'($urandom())};
      tr.delete();
      build(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_trace(ir, tr.size());
      for (int i = 0; i < tr.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== {tr[i].ctl, tr[i].alu}) begin
          n_fail++;
          $display("FAIL b2b instr %0d op %b step %0d: got %h, expected %h",
                   k, op, i, obs_q[i], {tr[i].ctl, tr[i].alu});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_wait();
    test_mul();
    test_back_to_back();
    test_clear_mid();
    test_stop_pulse();
    test_stop();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
